// File: rtl/fourinput_tsm_share_combiner.sv
// Two-beat share combiner for the four-input HO-TSM1 monomial generator.
// Optional output refresh: define TSM_OUTPUT_REFRESH_EN.
module fourinput_tsm_share_combiner #(
    parameter logic [15:0] ANF_COEFF = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:1] mono_share1,
    input  logic [15:1] mono_share2,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        phase_sel,
    input  logic        rand_out,
    output logic        out_share1,
    output logic        out_share2,
    output logic        out_valid,
    input  logic        out_ready
);

    typedef enum logic [2:0] {
        CAP0 = 3'd0,
        SUM0 = 3'd1,
        CAP1 = 3'd2,
        SUM1 = 3'd3,
        OUT  = 3'd4
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic        phase_q;
    logic        phase_d;
    logic [15:1] m1_q;
    logic [15:1] m2_q;
    logic        acc1_q;
    logic        acc2_q;
    logic        sel1;
    logic        sel2;
    logic        capture;
    logic        rnd;

`ifdef TSM_OUTPUT_REFRESH_EN
    assign rnd = rand_out;
`else
    logic unused_rand;
    assign unused_rand = rand_out;
    assign rnd = 1'b0;
`endif

    // Separate trees per share so the two halves never meet before the output.
    assign sel1 = ^(m1_q & ANF_COEFF[15:1]);
    assign sel2 = ^(m2_q & ANF_COEFF[15:1]);

    assign in_ready   = (state_q == CAP0) || (state_q == CAP1);
    assign out_valid  = (state_q == OUT);
    assign capture    = in_ready && in_valid;
    assign phase_sel  = phase_q;
    assign out_share1 = acc1_q;
    assign out_share2 = acc2_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            CAP0: if (in_valid) state_d = SUM0;
            SUM0: state_d = CAP1;
            CAP1: if (in_valid) state_d = SUM1;
            SUM1: state_d = OUT;
            OUT:  if (out_ready) state_d = CAP0;
            default: state_d = CAP0;
        endcase
        phase_d = (state_d == CAP1) || (state_d == SUM1) ||
                  (state_d == OUT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CAP0;
            phase_q <= 1'b0;
            m1_q    <= '0;
            m2_q    <= '0;
            acc1_q  <= 1'b0;
            acc2_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            if (capture) begin
                m1_q <= mono_share1;
                m2_q <= mono_share2;
            end
            if (state_q == SUM0) begin
                acc1_q <= sel1;
                acc2_q <= sel2;
            end else if (state_q == SUM1) begin
                acc1_q <= acc1_q ^ sel1 ^ ANF_COEFF[0] ^ rnd;
                acc2_q <= acc2_q ^ sel2 ^ rnd;
            end
        end
    end

endmodule

// File: doc/fourinput_tsm_share_combiner.md
# fourinput_tsm_share_combiner

Downstream stage of the four-input HO-TSM1 monomial generator. It consumes the 15 two-share monomial terms (x, y, z, w, xy … xyzw) in two time-shared beats: subscript0 in phase 0, then subscript1 in phase 1. For each beat it registers the terms, then folds the monomials selected by the function's algebraic normal form (ANF) into a two-share accumulator. After both beats it presents one two-share output bit of the Boolean function. Registers isolate every compression XOR tree from the combinational monomial logic upstream.

## Interface
- `ANF_COEFF`, default 16'h0000: ANF coefficient vector.
  - Bit 0 is the constant term.
  - Bit i (1..15) selects monomial i, using the upstream `rand_bit` index order: 1=x, 2=y, 3=z, 4=w, 5=xy, 6=xz, 7=xw, 8=yz, 9=yw, 10=zw, 11=xyz, 12=xyw, 13=xzw, 14=yzw, 15=xyzw.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `mono_share1` input [15:1]: share-1 of the 15 monomials for the current phase.
- `mono_share2` input [15:1]: share-2 of the 15 monomials for the current phase.
- `in_valid` input 1: the `mono_*` buses hold a valid beat.
- `in_ready` output 1: the block accepts a beat this cycle.
- `phase_sel` output 1: tells upstream which phase to present (0 = subscript0, 1 = subscript1).
- `rand_out` input 1: fresh random bit for output refresh (used only when refresh is compiled in).
- `out_share1`, `out_share2` output 1 each: output shares; f = out_share1 ^ out_share2.
- `out_valid` output 1: the output shares are valid.
- `out_ready` input 1: the consumer accepts the output.

## Operation
- States: CAP0 → SUM0 → CAP1 → SUM1 → OUT → CAP0.
- CAP0 / CAP1:
  - `in_ready` = 1.
  - When `in_valid` is high, the beat is captured into `m1_reg[15:1]` and `m2_reg[15:1]`, and the FSM advances.
  - When `in_valid` is low, the FSM holds.
- SUM0 (unconditional, one cycle):
  - acc1 ← XOR over i of (m1_reg[i] & ANF_COEFF[i]).
  - acc2 ← the same sum over m2_reg.
  - Then go to CAP1.
- SUM1 (unconditional, one cycle):
  - acc1 ← acc1 ^ sel(m1_reg) ^ ANF_COEFF[0].
  - acc2 ← acc2 ^ sel(m2_reg).
  - With refresh compiled in, acc1 and acc2 are each additionally XORed with `rand_out` (see Configuration).
  - Then go to OUT.
- OUT:
  - `out_valid` = 1 and `out_share1/2` = acc1/acc2.
  - The FSM holds until `out_ready` is high, then goes to CAP0.
  - Output values are stable while waiting.
- `phase_sel` = 0 in CAP0 and SUM0, 1 in CAP1, SUM1 and OUT.
- `phase_sel` changes only on a clock edge (registered, glitch-free).
- SUM0 and SUM1 read only registered data. Share-1 and share-2 terms are never mixed in the same XOR tree.
- Masked monomial inputs and the accumulators carry no unmasked secret. Only the XOR of the two shares equals f.

## Timing
- Reset values: state = CAP0, `in_ready` = 1, `phase_sel` = 0, `out_valid` = 0, `out_share1` = 0, `out_share2` = 0, m1_reg = m2_reg = acc1 = acc2 = 0.
- Reset asserted in any state: all of the above take effect on the next edge. Partial accumulations are discarded.
- Latency: the phase-1 beat accepted at edge k gives `out_valid` high after edge k+1.
- Minimum period is 5 cycles per output (zero stalls, `out_ready` tied high).
- `in_ready` is low in SUM0, SUM1 and OUT. Beats offered there are neither consumed nor lost (upstream holds them).
- `out_valid && out_ready` at edge j: `out_valid` is low and `in_ready` is high after edge j. No output is ever presented twice.
- `in_valid` held high continuously: exactly one beat is accepted per CAP state.

## Configuration
- `TSM_OUTPUT_REFRESH_EN` defined:
  - In SUM1, `rand_out` is XORed into both acc1 and acc2. f is unchanged; the share split is re-randomized.
  - `rand_out` is sampled only on the SUM1 edge.
- Not defined: `rand_out` is ignored (unconnected logic), and the output shares are the raw accumulation.

## Test plan
- Identity, linear function, refresh disabled:
  - Setup: `ANF_COEFF`=16'h0002 (f=x). Beat0 x-shares (1,0), beat1 x-shares (0,0). All other monomial shares 0.
  - Required: `out_share1`=1, `out_share2`=0 after 5 cycles; `phase_sel` sequence 0,0,1,1,1.
- Constant and product:
  - Setup: `ANF_COEFF`=16'h8001 (f=1^xyzw). Beat0 xyzw shares (1,1), beat1 (1,0).
  - Required: out_share1 ^ out_share2 = 0.
- Refresh enabled:
  - Setup: `rand_out`=1 at SUM1, otherwise the same stimulus as the identity case.
  - Required: `out_share1`=0, `out_share2`=1, XOR still 1.
- Backpressure:
  - Stimulus: hold `out_ready`=0 for 4 cycles in OUT and drive `in_valid`=1 throughout.
  - Required: outputs constant, `in_ready`=0, and the next beat is accepted only on the cycle after the `out_ready` handshake.
- Input stall:
  - Stimulus: `in_valid`=0 for 3 cycles in CAP1.
  - Required: FSM stays in CAP1, acc unchanged, final result correct.
- Mid-operation reset:
  - Stimulus: assert `rst` in SUM1.
  - Required: next cycle state=CAP0, `out_valid`=0, accumulators zero. The subsequent clean transaction produces the correct f.
